// File: rtl/lif_spike_generator.sv
// lif_spike_generator: leaky integrate-and-fire neuron output stage with shift leak and saturating potential
// Define REFRACTORY_EN to add the post-spike refractory period; without it the neuron integrates again on the next enable.
module lif_spike_generator #(
  parameter int THRESHOLD     = 64,
  parameter int DECAY_SHIFT   = 3,
  parameter int REFRAC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic signed [7:0] input_current,
  output logic              spike_out,
  output logic signed [7:0] membrane_potential,
  output logic              refractory_active
);
  localparam logic signed [7:0] TH = 8'(THRESHOLD);
  if (THRESHOLD < 1 || THRESHOLD > 127 || DECAY_SHIFT < 1 || DECAY_SHIFT > 7 ||
      REFRAC_CYCLES < 0 || REFRAC_CYCLES > 15) begin : g_bad_params
    $error("lif_spike_generator: parameter out of range");
  end
  logic signed [9:0] s;
  logic signed [7:0] v_next, v_d;
  logic              spike_d, fire;
  assign s      = 10'(membrane_potential) - 10'(membrane_potential >>> DECAY_SHIFT) + 10'(input_current);
  assign v_next = s > 10'sd127 ? 8'sd127 : s < -10'sd128 ? -8'sd128 : s[7:0];
  assign fire   = v_next >= TH;
`ifdef REFRACTORY_EN
  typedef enum logic {INTEGRATE, REFRACTORY} state_t;
  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= INTEGRATE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    v_d     = membrane_potential;
    spike_d = 1'b0;
    if (enable) begin
      if (state == REFRACTORY) begin
        v_d     = '0;
        cnt_d   = cnt - 4'd1;
        state_d = cnt == 4'd1 ? INTEGRATE : REFRACTORY;
      end else if (fire) begin
        v_d     = '0;
        spike_d = 1'b1;
        if (REFRAC_CYCLES > 0) begin
          state_d = REFRACTORY;
          cnt_d   = 4'(REFRAC_CYCLES);
        end
      end else begin
        v_d = v_next;
      end
    end
  end
  assign refractory_active = state == REFRACTORY;
`else
  always_comb begin
    spike_d = enable && fire;
    v_d     = !enable ? membrane_potential : fire ? 8'sd0 : v_next;
  end
  assign refractory_active = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      membrane_potential <= '0;
      spike_out          <= 1'b0;
    end else begin
      membrane_potential <= v_d;
      spike_out          <= spike_d;
    end
endmodule

// File: tb/tb_lif_spike_generator.sv
// tb_lif_spike_generator: scoreboard bench; a behavioural neuron model queues expected outputs per driven step
module tb_lif_spike_generator;
  localparam int TH = 64, DS = 3, RC = 2;
  logic              clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic signed [7:0] input_current = '0;
  logic              spike_out, refractory_active;
  logic signed [7:0] membrane_potential;
  typedef struct {logic sp; int v; logic ra;} exp_t;
  exp_t q[$];
  exp_t e;
  int vectors = 0, miscompares = 0;
  int mv = 0, mcnt = 0;

  lif_spike_generator #(.THRESHOLD(TH), .DECAY_SHIFT(DS), .REFRAC_CYCLES(RC)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .input_current(input_current),
    .spike_out(spike_out), .membrane_potential(membrane_potential),
    .refractory_active(refractory_active));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input int cur);
    exp_t x;
    int s;
    @(negedge clk);
    enable = en;
    input_current = 8'(cur);
    x.sp = 1'b0;
    if (en) begin
      if (mcnt > 0) begin
        mv = 0;
        mcnt--;
      end else begin
        s = mv - (mv >>> DS) + cur;
        s = s > 127 ? 127 : s < -128 ? -128 : s;
        if (s >= TH) begin
          mv = 0;
          x.sp = 1'b1;
`ifdef REFRACTORY_EN
          mcnt = RC;
`endif
        end else mv = s;
      end
    end
    x.v  = mv;
    x.ra = mcnt > 0;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("spike", 32'(spike_out), 32'(e.sp));
      check("v", 32'(membrane_potential), e.v);
      check("refr", 32'(refractory_active), 32'(e.ra));
    end
  end

  initial begin
    enable = 1'b1;
    input_current = 8'sd100;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_spike", 32'(spike_out), 0);
      check("rst_v", 32'(membrane_potential), 0);
      check("rst_refr", 32'(refractory_active), 0);
    end
    @(negedge clk);
    enable = 1'b0;
    reset_n = 1'b1;
    repeat (4) drive(1'b1, 20);
    repeat (2) drive(1'b1, 20);
    repeat (5) drive(1'b0, 127);
    repeat (3) drive(1'b1, -128);
    drive(1'b1, 127);
    repeat (4) drive(1'b1, 127);
    repeat (2) drive(1'b1, 127);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_refr", 32'(refractory_active), 0);
    check("mid_rst_v", 32'(membrane_potential), 0);
    check("mid_rst_spike", 32'(spike_out), 0);
    mv = 0;
    mcnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 20);
    repeat (3) drive(1'b1, -128);
    drive(1'b1, 127);
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 255) - 128);
    repeat (3) @(negedge clk);
    check("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
